// File: rtl/word_byte_unpacker.sv
// Streams a 1/2/4-byte word out one byte per valid/ready handshake; first byte is valid the cycle after Start.
// O/Last/OValid hold while OReady=0; no new word is accepted until the last byte has transferred.
module word_byte_unpacker #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] I,
  input  logic [1:0]  Size,
  input  logic        Start,
  output logic        InReady,
  output logic [7:0]  O,
  output logic        OValid,
  input  logic        OReady,
  output logic        Last,
  output logic        Err
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] shift_q, shift_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [31:0] load_val;

  // The selected bytes are placed so that the first one to send already sits at O.
  always_comb begin
    load_val = I;
    if (MSB_FIRST) begin
      case (Size)
        2'b00:   load_val = {I[7:0], 24'h0};
        2'b01:   load_val = {I[15:0], 16'h0};
        default: load_val = I;
      endcase
    end else begin
      case (Size)
        2'b00:   load_val = {24'h0, I[7:0]};
        2'b01:   load_val = {16'h0, I[15:0]};
        default: load_val = I;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          if (Size == 2'b11) begin
            err_d = 1'b1;
          end else begin
            shift_d = load_val;
            cnt_d   = (Size == 2'b00) ? 2'd0 : (Size == 2'b01) ? 2'd1 : 2'd3;
            state_d = SEND;
          end
        end
      end
      SEND: begin
        if (OReady) begin
          // The final byte is left in place so O keeps showing it while idle.
          if (cnt_q == 2'd0) begin
            state_d = IDLE;
          end else begin
            shift_d = MSB_FIRST ? (shift_q << 8) : (shift_q >> 8);
            cnt_d   = cnt_q - 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      shift_q <= 32'h0;
      cnt_q   <= 2'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign InReady = (state_q == IDLE);
  assign OValid  = (state_q == SEND);
  assign Last    = (state_q == SEND) && (cnt_q == 2'd0);
  assign Err     = err_q;
  assign O       = MSB_FIRST ? shift_q[31:24] : shift_q[7:0];

endmodule

// File: tb/tb_word_byte_unpacker.sv
// Bench for word_byte_unpacker: MSB-first and LSB-first instances share stimulus,
// a receiver shift-in register rebuilds each word from the MSB-first stream.
module tb_word_byte_unpacker;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [31:0] I;
  logic [1:0]  Size;
  logic        Start;
  logic        OReady;

  logic       rdy_m, vld_m, last_m, err_m;
  logic [7:0] o_m;
  logic       rdy_l, vld_l, last_l, err_l;
  logic [7:0] o_l;

  int checks = 0;
  int failures = 0;

  word_byte_unpacker #(.MSB_FIRST(1'b1)) u_msb (
    .Clock(Clock), .Reset(Reset), .I(I), .Size(Size), .Start(Start),
    .InReady(rdy_m), .O(o_m), .OValid(vld_m), .OReady(OReady), .Last(last_m), .Err(err_m)
  );

  word_byte_unpacker #(.MSB_FIRST(1'b0)) u_lsb (
    .Clock(Clock), .Reset(Reset), .I(I), .Size(Size), .Start(Start),
    .InReady(rdy_l), .O(o_l), .OValid(vld_l), .OReady(OReady), .Last(last_l), .Err(err_l)
  );

  always #5 Clock = ~Clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] w;
    logic [1:0]  sz;
    logic [7:0]  e [4];
    int          n;
    int          mode;
    bit          inject;
  } vec_t;

  vec_t tbl [6];

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  // Reference: byte k of an n-byte word in most-significant-first order.
  task automatic model_bytes(input logic [31:0] w, input int n, output logic [7:0] e [4]);
    for (int k = 0; k < 4; k++) begin
      e[k] = 8'h00;
      if (k < n) e[k] = 8'((w >> (8 * (n - 1 - k))) & 32'hFF);
    end
  endtask

  task automatic set_vec(input int k, input logic [31:0] w, input logic [1:0] sz,
                         input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input logic [7:0] b3, input int n, input int mode, input bit inj);
    tbl[k].w = w;  tbl[k].sz = sz;  tbl[k].n = n;  tbl[k].mode = mode;  tbl[k].inject = inj;
    tbl[k].e[0] = b0; tbl[k].e[1] = b1; tbl[k].e[2] = b2; tbl[k].e[3] = b3;
  endtask

  // mode 0: OReady always 1; mode 1: OReady 0,1,0,1...; mode 2: random OReady.
  task automatic run_word(input logic [31:0] w, input logic [1:0] sz, input logic [7:0] e [4],
                          input int n, input int mode, input bit inject);
    int          idx = 0;
    int          cyc = 0;
    bit          inj_done = 1'b0;
    logic [31:0] rx = 32'h0;
    logic [31:0] zext;
    logic [7:0]  ob;
    chk("idle_inready_m", 32'(rdy_m), 32'd1);
    chk("idle_inready_l", 32'(rdy_l), 32'd1);
    I = w; Size = sz; Start = 1'b1; OReady = 1'b0;
    step();
    Start = 1'b0;
    I = $urandom;
    while (idx < n && cyc < 64) begin
      case (mode)
        0:       OReady = 1'b1;
        1:       OReady = cyc[0];
        default: OReady = 1'($urandom_range(0, 1));
      endcase
      chk("send_ovalid_m", 32'(vld_m), 32'd1);
      chk("send_inready_m", 32'(rdy_m), 32'd0);
      chk("send_err_m", 32'(err_m), 32'd0);
      chk("byte_m", 32'(o_m), 32'(e[idx]));
      chk("last_m", 32'(last_m), 32'(idx == n - 1));
      chk("send_ovalid_l", 32'(vld_l), 32'd1);
      chk("send_err_l", 32'(err_l), 32'd0);
      chk("byte_l", 32'(o_l), 32'(e[n - 1 - idx]));
      chk("last_l", 32'(last_l), 32'(idx == n - 1));
      if (inject && idx == 1 && !inj_done) begin
        Start = 1'b1;
        Size = cyc[0] ? 2'b11 : 2'b10;
        I = ~w;
        inj_done = 1'b1;
      end else begin
        Start = 1'b0;
      end
      ob = o_m;
      step();
      if (OReady) begin
        rx = {rx[23:0], ob};
        idx++;
      end
      cyc++;
    end
    Start = 1'b0;
    Size = sz;
    chk("word_complete", 32'(idx), 32'(n));
    chk("done_ovalid_m", 32'(vld_m), 32'd0);
    chk("done_inready_m", 32'(rdy_m), 32'd1);
    chk("done_ovalid_l", 32'(vld_l), 32'd0);
    chk("done_inready_l", 32'(rdy_l), 32'd1);
    chk("idle_hold_o_m", 32'(o_m), 32'(e[n - 1]));
    zext = (n == 1) ? {24'h0, w[7:0]} : (n == 2) ? {16'h0, w[15:0]} : w;
    chk("receiver_word", rx, zext);
    if (mode == 0) chk("send_cycles", 32'(cyc), 32'(n));
  endtask

  task automatic do_err(input logic [31:0] w);
    I = w; Size = 2'b11; Start = 1'b1;
    step();
    Start = 1'b0;
    chk("err_pulse_m", 32'(err_m), 32'd1);
    chk("err_pulse_l", 32'(err_l), 32'd1);
    chk("err_ovalid_m", 32'(vld_m), 32'd0);
    chk("err_inready_m", 32'(rdy_m), 32'd1);
    step();
    chk("err_clear_m", 32'(err_m), 32'd0);
    chk("err_clear_l", 32'(err_l), 32'd0);
    chk("err_idle_ovalid", 32'(vld_m), 32'd0);
  endtask

  initial begin
    logic [7:0] e [4];
    int r;
    Reset = 1'b0; I = 32'h0; Size = 2'b00; Start = 1'b0; OReady = 1'b0;

    #3;
    chk("rst_inready", 32'(rdy_m), 32'd1);
    chk("rst_ovalid", 32'(vld_m), 32'd0);
    chk("rst_last", 32'(last_m), 32'd0);
    chk("rst_err", 32'(err_m), 32'd0);
    chk("rst_o_m", 32'(o_m), 32'h0);
    chk("rst_o_l", 32'(o_l), 32'h0);
    step();
    Reset = 1'b1;
    step();

    set_vec(0, 32'hDEADBEEF, 2'b10, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 4, 0, 1'b0);
    set_vec(1, 32'h1234ABCD, 2'b01, 8'hAB, 8'hCD, 8'h00, 8'h00, 2, 1, 1'b0);
    set_vec(2, 32'hFFFFFF7E, 2'b00, 8'h7E, 8'h00, 8'h00, 8'h00, 1, 0, 1'b0);
    set_vec(3, 32'h01020304, 2'b10, 8'h01, 8'h02, 8'h03, 8'h04, 4, 2, 1'b0);
    set_vec(4, 32'hCAFEF00D, 2'b10, 8'hCA, 8'hFE, 8'hF0, 8'h0D, 4, 0, 1'b1);
    set_vec(5, 32'h55558001, 2'b01, 8'h80, 8'h01, 8'h00, 8'h00, 2, 2, 1'b1);

    for (int k = 0; k < 6; k++)
      run_word(tbl[k].w, tbl[k].sz, tbl[k].e, tbl[k].n, tbl[k].mode, tbl[k].inject);

    do_err(32'h89ABCDEF);
    run_word(tbl[2].w, tbl[2].sz, tbl[2].e, tbl[2].n, 0, 1'b0);

    // Asynchronous reset between bytes 2 and 3 of a 4-byte word.
    I = 32'hDEADBEEF; Size = 2'b10; Start = 1'b1; OReady = 1'b1;
    step();
    Start = 1'b0;
    step();
    step();
    chk("pre_rst_byte3", 32'(o_m), 32'hBE);
    #2;
    Reset = 1'b0;
    #1;
    chk("async_rst_ovalid_m", 32'(vld_m), 32'd0);
    chk("async_rst_inready_m", 32'(rdy_m), 32'd1);
    chk("async_rst_ovalid_l", 32'(vld_l), 32'd0);
    chk("async_rst_last", 32'(last_m), 32'd0);
    step();
    Reset = 1'b1;
    step();
    chk("post_rst_ovalid", 32'(vld_m), 32'd0);
    run_word(tbl[3].w, tbl[3].sz, tbl[3].e, tbl[3].n, 0, 1'b0);

    for (int k = 0; k < 30; k++) begin
      r = $urandom_range(0, 7);
      if (r == 7) begin
        do_err($urandom);
      end else begin
        I = $urandom;
        Size = 2'(r % 3);
        model_bytes(I, nbytes(Size), e);
        run_word(I, Size, e, nbytes(Size), 2, r[0]);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/word_byte_unpacker.md
Name: word_byte_unpacker

Overview:
- Transmit-side counterpart of the 32-bit register's byte shift-in load mode (FunSel 3'b110).
- Accepts a 32-bit word plus a size code and streams it out one byte per handshake.
- A downstream register cleared and then loaded with FunSel 3'b110 per byte rebuilds the zero-extended value.
- Sits between the register file read port and an 8-bit memory or peripheral bus.

Parameters:
- MSB_FIRST, 1, 1 = most significant selected byte first (matches the shift-in receiver); 0 = least significant byte first.

Ports:
- Clock  input  1  rising-edge clock, sole clock.
- Reset  input  1  asynchronous, active-low reset.
- I  input  32  word to transmit.
- Size  input  2  00 = 1 byte (I[7:0]), 01 = 2 bytes (I[15:0]), 10 = 4 bytes (I[31:0]), 11 = illegal.
- Start  input  1  request valid; sampled with I and Size.
- InReady  output  1  block idle and able to accept Start.
- O  output  8  current output byte.
- OValid  output  1  O holds a valid byte.
- OReady  input  1  consumer accepts O this cycle.
- Last  output  1  current O is the final byte of the word.
- Err  output  1  one-cycle pulse: illegal Size rejected.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (ports Clock, Reset).
- Reset (Reset=0, independent of Clock):
  - State = IDLE.
  - InReady=1; OValid=0; Last=0; Err=0; O=8'h00.
  - Internal shift register and counter cleared.
  - Reset mid-transfer aborts the word; no further bytes are emitted.
- States: IDLE and SEND.
- IDLE:
  - InReady=1 and OValid=0.
  - Start=1 with Size in {00, 01, 10} at a rising edge:
    - Capture I into the shift register, pre-aligned so the first byte sits at O.
    - Load the remaining-byte counter with N-1, where N = 1, 2 or 4.
    - Go to SEND.
  - Start=1 with Size=11: stay in IDLE, Err=1 for exactly the following cycle, nothing captured.
  - Start=0: stay in IDLE.
- SEND:
  - InReady=0 and OValid=1.
  - Start is ignored; no Err is raised for Start in SEND.
  - Last=1 exactly when the counter equals 0.
  - O, Last and OValid stay stable while OReady=0 (no-stall-drop rule).
  - On a rising edge with OReady=1 and counter>0: shift 8 bits toward O, decrement the counter, stay in SEND.
  - On a rising edge with OReady=1 and counter=0: go to IDLE, OValid=0, InReady=1 from the next cycle.
- Byte order:
  - MSB_FIRST=1:
    - Size 00: I[7:0].
    - Size 01: I[15:8], I[7:0].
    - Size 10: I[31:24], I[23:16], I[15:8], I[7:0].
  - MSB_FIRST=0: the same bytes in reverse order (I[7:0] first).
- Latency:
  - Start accepted at edge k gives the first byte with OValid=1 in the cycle after edge k.
  - With OReady held high, an N-byte word takes N cycles in SEND.
  - The next Start can be accepted one cycle after the last byte transfers. There are no back-to-back words.
- Counter: 2 bits; never underflows, because the transition to IDLE happens at counter 0.
- Unused upper input bits are ignored for sizes 00 and 01. The receiver's zero-extension supplies them.
- O holds its last value in IDLE. Only OValid qualifies O.

Test Plan:
- Reset then Size=10, I=32'hDEADBEEF, OReady=1 -> bytes DE, AD, BE, EF on consecutive cycles; Last only on EF; InReady returns to 1 the cycle after EF.
- Size=01, I=32'h1234ABCD, OReady toggling 0,1,0,1 -> bytes AB then CD; O stable during the OReady=0 cycles; exactly 2 transfers.
- Size=00, I=32'hFFFFFF7E -> single byte 7E with Last=1. A bench-side Register32bit (clear, then FunSel 3'b110 per byte) holds 32'h0000007E. Repeat the check for the 4-byte case: 32'hDEADBEEF.
- Size=11 with Start=1 in IDLE -> Err=1 for one cycle; OValid stays 0; InReady stays 1; a following legal Start is accepted normally.
- Start pulsed during SEND with a different I -> ignored; the original word completes unchanged.
- Reset=0 asserted asynchronously between bytes 2 and 3 of a 4-byte word -> OValid=0 and InReady=1 immediately; after release, a new word starts cleanly from its first byte.
- MSB_FIRST=0, Size=10, I=32'h01020304 -> bytes 04, 03, 02, 01.
